// File: rtl/input_buffer_split.sv
// input_buffer_split: one buffer slice of a router input port.
// Flits are stored in a small FIFO. Each head flit then goes through routing
// computation (RC), switch allocation (SA) and a single switch-traversal (ST)
// cycle. Every output that faces the input-unit mux is forced to zero outside
// its own state, because the mux ORs all slices together.

module input_buffer_split #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int INFO_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DIRECTION  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_credit,
    output logic                  rc_valid,
    output logic [INFO_WIDTH-1:0] route_info,
    output logic [ADDR_WIDTH-1:0] route_addr,
    input  logic                  rc_ack,
    input  logic                  rc_resp_valid,
    input  logic [DIRECTION-1:0]  rc_resp_dir,
    input  logic [DIRECTION-1:0]  out_credit_avail,
    output logic                  sa_valid,
    output logic [INFO_WIDTH-1:0] sa_info,
    output logic [ADDR_WIDTH-1:0] sa_addr,
    input  logic                  sa_grant,
    output logic [WIDTH-1:0]      st_data,
    output logic [DIRECTION-1:0]  st_ctrl,
    output logic [DIRECTION-1:0]  out_credit_decre,
    output logic                  overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RC_REQ,
        RC_WAIT,
        SA_REQ,
        ST
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [DIRECTION-1:0]  dir;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  sa_ready;
    logic [WIDTH-1:0]      head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [INFO_WIDTH-1:0] head_info;

    // A full FIFO may still take a write in the ST cycle, since the pop frees
    // the slot in the same edge.
    assign full      = (count == FULL_COUNT);
    assign pop       = (state == ST);
    assign push      = in_valid && (!full || pop);
    assign head      = mem[rd_ptr];
    assign head_addr = head[WIDTH-1 -: ADDR_WIDTH];
    assign head_info = head[INFO_WIDTH-1:0];
    assign sa_ready  = |(dir & out_credit_avail);

    // Occupancy after this edge's push and pop; also decides where ST goes.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Flit storage; contents only matter once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (in_valid && full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Output direction from the RC unit, captured once per head flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= '0;
        end else if (state == RC_WAIT && rc_resp_valid) begin
            dir <= rc_resp_dir;
        end
    end

    // Pipeline state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; rc_resp_valid is only looked at after the ack was taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = RC_REQ;
            RC_REQ:  if (rc_ack) state_next = RC_WAIT;
            RC_WAIT: if (rc_resp_valid) state_next = SA_REQ;
            SA_REQ:  if (sa_grant && sa_ready) state_next = ST;
            ST:      state_next = (count_next != '0) ? RC_REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mux-facing outputs, zero unless the slice is in the matching state.
    always_comb begin
        rc_valid         = 1'b0;
        route_info       = '0;
        route_addr       = '0;
        sa_valid         = 1'b0;
        sa_info          = '0;
        sa_addr          = '0;
        st_data          = '0;
        st_ctrl          = '0;
        out_credit_decre = '0;
        in_credit        = 1'b0;
        case (state)
            RC_REQ: begin
                rc_valid   = 1'b1;
                route_info = head_info;
                route_addr = head_addr;
            end
            SA_REQ: begin
                if (sa_ready) begin
                    sa_valid = 1'b1;
                    sa_info  = head_info;
                    sa_addr  = head_addr;
                end
            end
            ST: begin
                st_data          = head;
                st_ctrl          = dir;
                out_credit_decre = dir;
                in_credit        = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/input_buffer_split.md
Name: input_buffer_split

Overview:
- One buffer slice of a router input port. ROUTER_FIFO_SPLIT instances sit in parallel in front of the input-unit mux stage.
- Each slice stores incoming flits in a FIFO and runs a per-head-flit pipeline: routing computation (RC), then switch allocation (SA), then switch traversal (ST).
- Every output facing the mux must be all-zero when inactive, because the mux OR-combines the slices.

Parameters:
- WIDTH, 32, flit width (`ROUTER_WIDTH).
- DEPTH, 4, FIFO entries (power of 2, >= 2).
- INFO_WIDTH, 4, routing info field width (`ROUTER_INFO_WIDTH).
- ADDR_WIDTH, 8, routing address field width (`ROUTER_ADDR_WIDTH).
- DIRECTION, 5, number of output ports (`DIRECTION).

Ports:
- clk, input, 1, clock; all state on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, flit write strobe from upstream.
- in_data, input, WIDTH, flit. addr = in_data[WIDTH-1 -: ADDR_WIDTH]; info = in_data[INFO_WIDTH-1:0].
- in_credit, output, 1, one-cycle pulse when an entry is freed (to the mux in_credit_split).
- rc_valid, output, 1, RC request; feeds the mux rc_grant_split bit.
- route_info, output, INFO_WIDTH, head info; zero unless rc_valid.
- route_addr, output, ADDR_WIDTH, head addr; zero unless rc_valid.
- rc_ack, input, 1, RC unit accepted this slice's request this cycle.
- rc_resp_valid, input, 1, RC result valid.
- rc_resp_dir, input, DIRECTION, one-hot output direction.
- out_credit_avail, input, DIRECTION, per-direction downstream credit available.
- sa_valid, output, 1, SA request.
- sa_info, output, INFO_WIDTH, head info; zero unless sa_valid.
- sa_addr, output, ADDR_WIDTH, head addr; zero unless sa_valid.
- sa_grant, input, 1, switch allocator grant to this slice.
- st_data, output, WIDTH, traversing flit; zero outside ST.
- st_ctrl, output, DIRECTION, one-hot crossbar select; zero outside ST.
- out_credit_decre, output, DIRECTION, one-hot downstream credit consume pulse.
- overflow_err, output, 1, sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and count are 0; state is IDLE; latched direction is 0; overflow_err is 0.
  - All outputs are 0 immediately, without waiting for a clock edge.
- FIFO:
  - Write on in_valid. Entries are registered and readable the cycle after the write.
  - When not full, or full with a pop in the same cycle: the write is accepted.
  - When full and no pop: the write is dropped and overflow_err sets and stays set until reset.
  - Pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
- FSM:
  - IDLE: count != 0 -> RC_REQ next cycle. All handshake outputs are 0.
  - RC_REQ:
    - rc_valid=1; route_info and route_addr come from the head entry.
    - Stay here until rc_ack. On rc_ack -> RC_WAIT.
  - RC_WAIT:
    - On rc_resp_valid, latch rc_resp_dir -> SA_REQ.
    - rc_resp_valid arriving in the same cycle as rc_ack is ignored; the RC unit has a minimum latency of 1.
  - SA_REQ:
    - sa_valid = |(dir & out_credit_avail); sa_info and sa_addr are driven only while sa_valid.
    - If sa_grant && sa_valid -> ST. sa_grant while sa_valid=0 is ignored.
    - If credit drops while requesting, sa_valid falls in the same cycle; there is no latching.
  - ST, exactly one cycle:
    - st_data = head; st_ctrl = dir; out_credit_decre = dir; in_credit = 1; FIFO pops.
    - Next state: RC_REQ if count after pop and push != 0, else IDLE.
- Latency: for a flit written into an empty slice at cycle 0, with rc_ack immediate, response at cycle +1 and immediate grant:
  - rc_valid at cycle 2, ST at cycle 5.
  - Steady-state throughput is one flit per 4 cycles per slice.
- Mux-facing outputs (route_*, sa_*, st_*, in_credit, out_credit_decre) are combinational from state and registered data. They are never X and never nonzero outside their state.
- Simultaneous push and pop: count is unchanged; the flit behind the head becomes the new head.
- A malformed rc_resp_dir (non-one-hot) is used as-is; checking it is the RC unit's responsibility.

Test Plan:
- Reset, then a single flit in_data=0xA500_0003 at cycle 0, with rc_ack at 2, rc_resp_valid with dir=5'b00100 at 3, out_credit_avail=all-1 and sa_grant at 4:
  - Required: route_addr=0xA5 and route_info=0x3 only at cycle 2.
  - Required: st_data=0xA500_0003, st_ctrl=00100, out_credit_decre=00100, in_credit=1 only at cycle 5.
  - Required: IDLE afterwards with all outputs 0.
- Write 4 back-to-back flits (DEPTH=4), then a 5th with no pop:
  - Required: overflow_err=1 and stays set; the 5th flit is dropped.
  - Required: the 4 flits exit in order, with 4 in_credit pulses.
- Hold out_credit_avail[2]=0 for 6 cycles in SA_REQ with dir=00100:
  - Required: sa_valid=0 and sa_addr=0 throughout; sa_grant pulses during this time cause no ST.
  - Required: after credit returns, sa_valid=1 and ST follows the next sa_grant.
- Full FIFO with a write in the ST cycle: the write is accepted, count stays 4, overflow_err stays 0.
- Deassert rst_n asynchronously mid-RC_WAIT with 2 flits stored: outputs go to 0 before the next clock edge; after release, a new flit goes through normally.
- rc_ack held low for 10 cycles: rc_valid stays 1 with a stable route_addr; rc_resp_valid arriving before rc_ack is ignored.
